// File: rtl/wta_ctrl_pkg.sv
// Shared types for the WTA epoch controller: FSM state encoding, the
// per-period result record and the default column geometry.
package wta_ctrl_pkg;

  // Default column geometry; the controller's parameters default to these.
  localparam int unsigned NEURONS_PER_COLUMN = 16;
  localparam int unsigned GAMMA_CYCLES_DEF   = 8;
  localparam int unsigned RES_ID_W           = $clog2(NEURONS_PER_COLUMN);
  localparam int unsigned RES_TIME_W         = $clog2(GAMMA_CYCLES_DEF);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } wta_state_e;

  // One period's outcome as handed downstream. "time" is a reserved word,
  // so the spike-time field is called spike_time.
  typedef struct packed {
    logic                  none;
    logic [RES_ID_W-1:0]   winner;
    logic [RES_TIME_W-1:0] spike_time;
  } wta_result_t;

endpackage

// File: rtl/period_timer.sv
// Loadable modulo-GAMMA_CYCLES up-counter that produces the timestep index
// of a gamma period and flags its final timestep.
module period_timer #(
  parameter int unsigned GAMMA_CYCLES = 8,
  parameter int unsigned TIME_W       = $clog2(GAMMA_CYCLES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  output logic [TIME_W-1:0] count,
  output logic              last
);

  localparam logic [TIME_W-1:0] LAST_CNT = TIME_W'(GAMMA_CYCLES - 1);

  logic [TIME_W-1:0] count_q, count_d;

  // Next count: load wins over enable; wrap after the last timestep.
  always_comb begin
    // NOTE: the default assignment first means every path drives count_d,
    // so no latch can be inferred.
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == LAST_CNT) ? '0 : count_q + TIME_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the pre-edge values regardless of block ordering.
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == LAST_CNT);

endmodule

// File: rtl/wta_epoch_controller.sv
// Sequences the WTA lateral-inhibition stage over gamma periods, captures
// the first winner of each period and hands one result per period
// downstream over a valid/ready handshake.
module wta_epoch_controller
  import wta_ctrl_pkg::*;
#(
  parameter  int unsigned NEURONS      = NEURONS_PER_COLUMN,
  parameter  int unsigned GAMMA_CYCLES = GAMMA_CYCLES_DEF,
  parameter  int unsigned TIME_W       = $clog2(GAMMA_CYCLES),
  parameter  int unsigned EPOCH_W      = 16,
  localparam int unsigned ID_W         = $clog2(NEURONS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               run,
  input  logic               abort,
  input  logic [ID_W-1:0]    winner,
  input  logic               no_winner,
  output logic               clear,
  output logic               active,
  output logic [TIME_W-1:0]  timestep,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [ID_W-1:0]    res_winner,
  output logic [TIME_W-1:0]  res_time,
  output logic               res_none,
  output logic [EPOCH_W-1:0] epochs
);

  localparam logic [TIME_W-1:0] LAST_T = TIME_W'(GAMMA_CYCLES - 1);

  wta_state_e         state_q, state_d;
  logic [TIME_W-1:0]  count;
  logic               last;
  logic               in_run, in_report, handshake, period_done;

  logic               cap_flag_q, cap_flag_d;
  logic [ID_W-1:0]    cap_winner_q, cap_winner_d;
  logic [TIME_W-1:0]  cap_time_q, cap_time_d;

  wta_result_t        res_q, res_d;
  logic [EPOCH_W-1:0] epochs_q, epochs_d;

  assign in_run      = (state_q == RUN);
  assign in_report   = (state_q == REPORT);
  // abort beats res_ready, so an aborted report never counts as accepted.
  assign handshake   = in_report && res_ready && !abort;
  assign period_done = in_run && last && !abort;

  // The timer free-runs only in RUN and is parked at 0 everywhere else, so
  // every entry into RUN starts at timestep 0.
  period_timer #(
    .GAMMA_CYCLES (GAMMA_CYCLES),
    .TIME_W       (TIME_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (!in_run),
    .en    (in_run),
    .count (count),
    .last  (last)
  );

  // Next-state logic: abort returns to IDLE from RUN or REPORT; run is
  // looked at only when the result is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort)     state_d = IDLE;
        else if (last) state_d = REPORT;
      end
      REPORT: begin
        if (abort)          state_d = IDLE;
        else if (res_ready) state_d = run ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // First-spike capture within RUN; the flag is held clear outside RUN so
  // each period starts with nothing captured.
  always_comb begin
    cap_flag_d   = cap_flag_q;
    cap_winner_d = cap_winner_q;
    cap_time_d   = cap_time_q;
    if (in_run) begin
      if (!cap_flag_q && !no_winner) begin
        cap_flag_d   = 1'b1;
        cap_winner_d = winner;
        cap_time_d   = count;
      end
    end else begin
      cap_flag_d = 1'b0;
    end
  end

  // Result record loads only on the final RUN timestep. It uses the
  // next-state capture so a spike on that very timestep is not lost.
  always_comb begin
    res_d = res_q;
    if (period_done) begin
      res_d.none       = !cap_flag_d;
      res_d.winner     = cap_flag_d ? cap_winner_d : '0;
      res_d.spike_time = cap_flag_d ? cap_time_d : LAST_T;
    end
  end

  // Accepted-result counter, wrapping naturally at 2^EPOCH_W.
  always_comb begin
    epochs_d = epochs_q + EPOCH_W'(handshake);
  end

  // State, capture, result and epoch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cap_flag_q   <= 1'b0;
      cap_winner_q <= '0;
      cap_time_q   <= '0;
      res_q        <= '0;
      epochs_q     <= '0;
    end else begin
      state_q      <= state_d;
      cap_flag_q   <= cap_flag_d;
      cap_winner_q <= cap_winner_d;
      cap_time_q   <= cap_time_d;
      res_q        <= res_d;
      epochs_q     <= epochs_d;
    end
  end

  assign active     = in_run;
  assign clear      = in_run && (count == '0);
  assign timestep   = in_run ? count : '0;
  assign res_valid  = in_report;
  assign res_none   = res_q.none;
  assign res_winner = res_q.winner;
  assign res_time   = res_q.spike_time;
  assign epochs     = epochs_q;

endmodule

// File: tb/tb_wta_epoch_controller.sv
// Self-checking bench for wta_epoch_controller: scenario tasks with
// randomized spike patterns against a first-spike reference model.
`timescale 1ns/1ps
module tb_wta_epoch_controller;

  localparam int GC   = 8;
  localparam int ID_W = 4;
  localparam int TW   = 3;
  localparam int EW   = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0, run = 1'b0, abort = 1'b0;
  logic [ID_W-1:0] winner = '0;
  logic            no_winner = 1'b1;
  logic            res_ready = 1'b0;
  logic            clear, active, res_valid, res_none;
  logic [TW-1:0]   timestep, res_time;
  logic [ID_W-1:0] res_winner;
  logic [EW-1:0]   epochs;

  wta_epoch_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .run        (run),
    .abort      (abort),
    .winner     (winner),
    .no_winner  (no_winner),
    .clear      (clear),
    .active     (active),
    .timestep   (timestep),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_winner (res_winner),
    .res_time   (res_time),
    .res_none   (res_none),
    .epochs     (epochs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    tests = 0;
  int    fails = 0;
  string scen;

  // Stimulus pattern for one period and the values the result port must hold.
  logic            no_win_pat[GC];
  logic [ID_W-1:0] win_pat[GC];
  logic            h_none;
  logic [ID_W-1:0] h_win;
  logic [TW-1:0]   h_time;
  logic [EW-1:0]   exp_epochs;
  int              clear_cyc[$];

  // Reference: the result is the earliest timestep with a spike, or "none".
  function automatic void model_result(output logic none, output logic [ID_W-1:0] w,
                                       output logic [TW-1:0] t);
    none = 1'b1;
    w    = '0;
    t    = TW'(GC - 1);
    for (int i = 0; i < GC; i++) begin
      if (none && !no_win_pat[i]) begin
        none = 1'b0;
        w    = win_pat[i];
        t    = TW'(i);
      end
    end
  endfunction

  task automatic gen_silent();
    for (int i = 0; i < GC; i++) begin
      no_win_pat[i] = 1'b1;
      win_pat[i]    = ID_W'($urandom);
    end
  endtask

  task automatic gen_random(input int density);
    for (int i = 0; i < GC; i++) begin
      no_win_pat[i] = ($urandom_range(0, 99) >= density);
      win_pat[i]    = ID_W'($urandom);
    end
  endtask

  // From IDLE: pulse start with junk spike inputs (ignored outside RUN).
  task automatic start_period();
    start     = 1'b1;
    no_winner = 1'b0;
    winner    = ID_W'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Walk one RUN period; abort_at >= 0 aborts at that timestep.
  task automatic play_period(input int abort_at, input logic rand_start);
    for (int t = 0; t < GC; t++) begin
      tests++;
      if (active !== 1'b1 || timestep !== TW'(t)) begin
        fails++;
        $display("FAIL %s run_t%0d: active=%b timestep=%0d, expected active=1 timestep=%0d",
                 scen, t, active, timestep, t);
      end
      tests++;
      if (clear !== 1'(t == 0)) begin
        fails++;
        $display("FAIL %s clear_t%0d: clear=%b, expected %b", scen, t, clear, t == 0);
      end
      if (clear === 1'b1) clear_cyc.push_back(cyc);
      tests++;
      if (res_valid !== 1'b0 || res_none !== h_none || res_winner !== h_win ||
          res_time !== h_time || epochs !== exp_epochs) begin
        fails++;
        $display("FAIL %s hold_t%0d: valid=%b none=%b win=%0d time=%0d epochs=%0d, expected 0 %b %0d %0d %0d",
                 scen, t, res_valid, res_none, res_winner, res_time, epochs,
                 h_none, h_win, h_time, exp_epochs);
      end
      no_winner = no_win_pat[t];
      winner    = win_pat[t];
      start     = rand_start ? 1'($urandom_range(0, 1)) : 1'b0;
      abort     = (t == abort_at);
      @(posedge clk); #1;
      if (t == abort_at) begin
        abort     = 1'b0;
        start     = 1'b0;
        no_winner = 1'b1;
        tests++;
        if (active !== 1'b0 || res_valid !== 1'b0 || clear !== 1'b0 || timestep !== '0 ||
            epochs !== exp_epochs || res_none !== h_none || res_winner !== h_win ||
            res_time !== h_time) begin
          fails++;
          $display("FAIL %s abort_idle: active=%b valid=%b ts=%0d epochs=%0d none=%b win=%0d time=%0d, expected idle epochs=%0d held %b %0d %0d",
                   scen, active, res_valid, timestep, epochs, res_none, res_winner, res_time,
                   exp_epochs, h_none, h_win, h_time);
        end
        return;
      end
    end
    start     = 1'b0;
    no_winner = 1'($urandom_range(0, 1));
    winner    = ID_W'($urandom);
  endtask

  // First REPORT cycle: compare against the model, then hold those values.
  task automatic check_report();
    logic            e_none;
    logic [ID_W-1:0] e_w;
    logic [TW-1:0]   e_t;
    model_result(e_none, e_w, e_t);
    tests++;
    if (res_valid !== 1'b1 || active !== 1'b0 || clear !== 1'b0 || timestep !== '0) begin
      fails++;
      $display("FAIL %s report_state: valid=%b active=%b clear=%b ts=%0d, expected 1 0 0 0",
               scen, res_valid, active, clear, timestep);
    end
    tests++;
    if (res_none !== e_none || res_winner !== e_w || res_time !== e_t) begin
      fails++;
      $display("FAIL %s result: none=%b win=%0d time=%0d, expected none=%b win=%0d time=%0d",
               scen, res_none, res_winner, res_time, e_none, e_w, e_t);
    end
    h_none = e_none;
    h_win  = e_w;
    h_time = e_t;
  endtask

  // Hold off res_ready for delay cycles, then accept with run=run_next.
  task automatic handshake(input int delay, input logic run_next);
    for (int d = 0; d < delay; d++) begin
      res_ready = 1'b0;
      run       = 1'($urandom_range(0, 1));
      start     = 1'($urandom_range(0, 1));
      no_winner = 1'($urandom_range(0, 1));
      winner    = ID_W'($urandom);
      @(posedge clk); #1;
      tests++;
      if (res_valid !== 1'b1 || active !== 1'b0 || clear !== 1'b0 || epochs !== exp_epochs ||
          res_none !== h_none || res_winner !== h_win || res_time !== h_time) begin
        fails++;
        $display("FAIL %s stall_%0d: valid=%b active=%b clear=%b epochs=%0d none=%b win=%0d time=%0d, expected 1 0 0 %0d %b %0d %0d",
                 scen, d, res_valid, active, clear, epochs, res_none, res_winner, res_time,
                 exp_epochs, h_none, h_win, h_time);
      end
    end
    res_ready = 1'b1;
    run       = run_next;
    start     = 1'b0;
    @(posedge clk); #1;
    res_ready  = 1'b0;
    exp_epochs = exp_epochs + 1'b1;
    tests++;
    if (epochs !== exp_epochs) begin
      fails++;
      $display("FAIL %s epochs: got %0d, expected %0d", scen, epochs, exp_epochs);
    end
    tests++;
    if (res_valid !== 1'b0 || active !== run_next || clear !== run_next ||
        res_none !== h_none || res_winner !== h_win || res_time !== h_time) begin
      fails++;
      $display("FAIL %s after_hs: valid=%b active=%b clear=%b none=%b win=%0d time=%0d, expected 0 %b %b held %b %0d %0d",
               scen, res_valid, active, clear, res_none, res_winner, res_time,
               run_next, run_next, h_none, h_win, h_time);
    end
  endtask

  task automatic test_reset();
    scen = "reset";
    rst_n = 1'b0;
    #1;
    tests++;
    if ({clear, active, timestep, res_valid, res_winner, res_time, res_none, epochs} !== '0) begin
      fails++;
      $display("FAIL %s outputs: clear=%b active=%b ts=%0d valid=%b win=%0d time=%0d none=%b epochs=%0d, expected all 0",
               scen, clear, active, timestep, res_valid, res_winner, res_time, res_none, epochs);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    exp_epochs = '0;
    h_none = 1'b0; h_win = '0; h_time = '0;
    // No start: spike inputs and the other controls must leave IDLE alone.
    for (int i = 0; i < 3; i++) begin
      no_winner = 1'b0;
      winner    = ID_W'($urandom);
      res_ready = 1'($urandom_range(0, 1));
      run       = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      tests++;
      if (active !== 1'b0 || res_valid !== 1'b0 || clear !== 1'b0 || epochs !== '0 ||
          res_none !== 1'b0 || res_winner !== '0 || res_time !== '0) begin
        fails++;
        $display("FAIL %s idle_%0d: active=%b valid=%b clear=%b epochs=%0d none=%b win=%0d time=%0d, expected all 0",
                 scen, i, active, res_valid, clear, epochs, res_none, res_winner, res_time);
      end
    end
    res_ready = 1'b0;
    run       = 1'b0;
  endtask

  // Fixed pattern: given (timestep, winner) spikes on a silent background.
  task automatic test_fixed(input string name, input int t0, input logic [ID_W-1:0] w0,
                            input int t1, input logic [ID_W-1:0] w1);
    scen = name;
    gen_silent();
    if (t0 >= 0) begin no_win_pat[t0] = 1'b0; win_pat[t0] = w0; end
    if (t1 >= 0) begin no_win_pat[t1] = 1'b0; win_pat[t1] = w1; end
    start_period();
    play_period(-1, 1'b0);
    check_report();
    handshake(0, 1'b0);
  endtask

  task automatic test_continuous();
    scen = "continuous";
    clear_cyc.delete();
    start_period();
    for (int p = 0; p < 3; p++) begin
      gen_random(30);
      play_period(-1, 1'b1);
      check_report();
      handshake(0, 1'(p < 2));
    end
    tests++;
    if (clear_cyc.size() != 3) begin
      fails++;
      $display("FAIL %s clear_count: got %0d pulses, expected 3", scen, clear_cyc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        tests++;
        if (clear_cyc[i] - clear_cyc[i-1] != GC + 1) begin
          fails++;
          $display("FAIL %s clear_gap_%0d: got %0d cycles, expected %0d",
                   scen, i, clear_cyc[i] - clear_cyc[i-1], GC + 1);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    scen = "backpressure";
    gen_random(40);
    start_period();
    play_period(-1, 1'b0);
    check_report();
    handshake(5, 1'b0);
  endtask

  task automatic test_abort();
    scen = "abort_run";
    gen_silent();
    no_win_pat[2] = 1'b0;
    win_pat[2]    = 4'd9;
    start_period();
    play_period(5, 1'b0);
    @(posedge clk); #1;
    tests++;
    if (active !== 1'b0 || res_valid !== 1'b0 || epochs !== exp_epochs) begin
      fails++;
      $display("FAIL %s stays_idle: active=%b valid=%b epochs=%0d, expected 0 0 %0d",
               scen, active, res_valid, epochs, exp_epochs);
    end
    scen = "abort_report";
    gen_random(30);
    start_period();
    play_period(-1, 1'b0);
    check_report();
    res_ready = 1'b1;
    run       = 1'b1;
    abort     = 1'b1;
    @(posedge clk); #1;
    abort     = 1'b0;
    res_ready = 1'b0;
    run       = 1'b0;
    tests++;
    if (active !== 1'b0 || res_valid !== 1'b0 || clear !== 1'b0 || epochs !== exp_epochs) begin
      fails++;
      $display("FAIL %s priority: active=%b valid=%b clear=%b epochs=%0d, expected 0 0 0 %0d",
               scen, active, res_valid, clear, epochs, exp_epochs);
    end
  endtask

  task automatic test_random();
    logic run_next = 1'b0;
    scen = "random";
    for (int p = 0; p < 8; p++) begin
      gen_random((p % 3 == 0) ? 0 : 25);
      if (!run_next) start_period();
      play_period(-1, 1'b1);
      check_report();
      run_next = (p < 7) ? 1'($urandom_range(0, 1)) : 1'b0;
      handshake(int'($urandom_range(0, 3)), run_next);
    end
  endtask

  task automatic test_async_reset();
    scen = "async_reset";
    gen_random(50);
    start_period();
    play_period(-1, 1'b0);
    check_report();
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({clear, active, timestep, res_valid, res_winner, res_time, res_none, epochs} !== '0) begin
      fails++;
      $display("FAIL %s outputs: clear=%b active=%b ts=%0d valid=%b win=%0d time=%0d none=%b epochs=%0d, expected all 0",
               scen, clear, active, timestep, res_valid, res_winner, res_time, res_none, epochs);
    end
    exp_epochs = '0;
    h_none = 1'b0; h_win = '0; h_time = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (active !== 1'b0 || res_valid !== 1'b0 || epochs !== '0) begin
      fails++;
      $display("FAIL %s post_reset: active=%b valid=%b epochs=%0d, expected 0 0 0",
               scen, active, res_valid, epochs);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fixed("spike_t3", 3, 4'd5, -1, '0);
    test_fixed("silent", -1, '0, -1, '0);
    test_fixed("multi_spike", 1, 4'd2, 4, 4'd7);
    test_fixed("spike_t0", 0, 4'd11, 5, 4'd3);
    test_fixed("spike_last", GC - 1, 4'd14, -1, '0);
    test_continuous();
    test_backpressure();
    test_abort();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
